run_ctrl: RTL



---
 rtl/minitb_pkg.sv | 14 +
 rtl/run_ctrl_bp.sv | 46 ++++
 rtl/run_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/minitb_pkg.sv
// miniTB04 shared constants: run/debug state encoding and micro-cycle bounds.
package minitb_pkg;

    localparam int DEFAULT_PC_W = 12;

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_DRAIN = 2'b11;

    localparam logic [2:0] CYCLE_FIRST = 3'd0;
    localparam logic [2:0] CYCLE_LAST  = 3'd7;

endpackage

// File: rtl/run_ctrl_bp.sv
// Single PC breakpoint: address compare at the instruction boundary, a skip
// flag that lets a resume step off the breakpoint address, and a sticky hit flag.
import minitb_pkg::*;

module run_ctrl_bp #(
    parameter int PC_W = DEFAULT_PC_W
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_in_run,
    input  logic [2:0]      i_cycle,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_bp_valid,
    input  logic [PC_W-1:0] i_bp_addr,
    input  logic            i_cpu_ce,
    input  logic            i_resume,
    output logic            o_bp_trap,
    output logic            o_bp_hit
);

    logic r_skip;
    logic r_hit;

    assign o_bp_trap = i_bp_valid & i_in_run & (i_cycle == CYCLE_FIRST)
                     & (i_pc == i_bp_addr) & ~r_skip;
    assign o_bp_hit  = r_hit;

    // Resume arms the skip and clears the hit; the first passed enable disarms skip.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_skip <= 1'b0;
            r_hit  <= 1'b0;
        end else if (i_resume) begin
            r_skip <= 1'b1;
            r_hit  <= 1'b0;
        end else begin
            if (i_cpu_ce) begin
                r_skip <= 1'b0;
            end
            if (o_bp_trap) begin
                r_hit <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run/debug sequencer for the miniTB04 CPU. Qualifies the raw clkCtrl tick
// into cpu_ce and provides run, halt, single-step and one PC breakpoint.
// Halts always land on an instruction boundary (cycle 0).
// Optional feature macro: RUN_CTRL_BP_EN (breakpoint logic; absent by default).
//
// state | meaning
// HALT  | CPU frozen at an instruction boundary, cpu_ce held low
// RUN   | free-running, breakpoint armed
// STEP  | executing exactly one instruction, then back to HALT
// DRAIN | halt requested mid-instruction, finishing the current instruction
import minitb_pkg::*;

module run_ctrl #(
    parameter int PC_W         = DEFAULT_PC_W,
    parameter int CNT_W        = 16,
    parameter int RUN_AT_RESET = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             tick,
    input  logic [2:0]       cycle,
    input  logic [PC_W-1:0]  pc,
    input  logic             cmd_run,
    input  logic             cmd_halt,
    input  logic             cmd_step,
    input  logic             bp_valid,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic             insn_done,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [1:0] ST_RESET = (RUN_AT_RESET != 0) ? ST_RUN : ST_HALT;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_insn_done;
    logic [CNT_W-1:0] r_retire_cnt;
    logic             w_bp_trap;
    logic             w_retire;
    logic             w_boundary;

    assign cpu_ce     = tick & nrst & (r_state != ST_HALT) & ~w_bp_trap;
    assign w_retire   = cpu_ce & (cycle == CYCLE_LAST);
    assign w_boundary = (cycle == CYCLE_FIRST);

`ifdef RUN_CTRL_BP_EN
    logic w_in_run;
    logic w_resume;

    assign w_in_run = (r_state == ST_RUN);
    assign w_resume = (r_state == ST_HALT) & (cmd_run | cmd_step);

    run_ctrl_bp #(
        .PC_W (PC_W)
    ) u_bp (
        .clk        (clk),
        .nrst       (nrst),
        .i_in_run   (w_in_run),
        .i_cycle    (cycle),
        .i_pc       (pc),
        .i_bp_valid (bp_valid),
        .i_bp_addr  (bp_addr),
        .i_cpu_ce   (cpu_ce),
        .i_resume   (w_resume),
        .o_bp_trap  (w_bp_trap),
        .o_bp_hit   (bp_hit)
    );
`else
    logic w_unused_bp;

    assign w_unused_bp = ^{bp_valid, bp_addr, pc};
    assign w_bp_trap   = 1'b0;
    assign bp_hit      = 1'b0;
`endif

    // Next-state decode; within a clock halt beats run beats step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HALT: begin
                if (cmd_run) begin
                    w_state_nxt = ST_RUN;
                end else if (cmd_step) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                // A trap already sits on the boundary, so it wins over a
                // concurrent halt that would otherwise drain a full instruction.
                if (w_bp_trap) begin
                    w_state_nxt = ST_HALT;
                end else if (cmd_halt) begin
                    w_state_nxt = (w_boundary && !tick) ? ST_HALT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cmd_run && !cmd_halt) begin
                    w_state_nxt = ST_RUN;
                end else if (w_retire) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_STEP: begin
                if (cmd_halt) begin
                    w_state_nxt = w_retire ? ST_HALT : ST_DRAIN;
                end else if (cmd_run) begin
                    w_state_nxt = ST_RUN;
                end else if (w_retire) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Retirement pulse and wrapping retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_insn_done  <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_insn_done <= w_retire;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign state      = r_state;
    assign halted     = (r_state == ST_HALT);
    assign insn_done  = r_insn_done;
    assign retire_cnt = r_retire_cnt;

endmodule
